sha_uart_host: RTL
==================

SHA_UART_HOST -- requirements
Module: sha_uart_host

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 24'd1000000, response-idle cycles before abort (used only with SHA_HOST_TIMEOUT_EN).
REQ-002 clk  input  1  single clock; all logic SHALL be clocked on posedge clk.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a hash of block; sampled only in IDLE.
REQ-005 block  input  512  message block; block[511:504] is sent first.
REQ-006 busy  output  1  high in every state except IDLE.
REQ-007 m_axis_tdata  output  8  byte toward UART transmitter.
REQ-008 m_axis_tvalid  output  1  m_axis byte valid.
REQ-009 m_axis_tready  input  1  transmitter accepts byte.
REQ-010 s_axis_tdata  input  8  byte from UART receiver.
REQ-011 s_axis_tvalid  input  1  s_axis byte valid.
REQ-012 s_axis_tready  output  1  block accepts byte.
REQ-013 digest  output  160  last completed digest; first received byte lands in digest[159:152].
REQ-014 digest_valid  output  1  one-cycle pulse when digest updates.
REQ-015 timeout_err  output  1  one-cycle pulse on response timeout.

Function
REQ-016 The FSM SHALL have states IDLE, SEND, RECV.
REQ-017 IDLE: s_axis_tready=1, incoming bytes discarded; start=1 in cycle N SHALL capture block into a 512-bit shift register, load byte count 64, enter SEND; m_axis_tvalid=1 in cycle N+1.
REQ-018 start while busy SHALL be ignored; block is sampled only at the accepting edge.
REQ-019 SEND: m_axis_tvalid=1, m_axis_tdata = top byte of shift register; s_axis_tready=0.
REQ-020 A transfer occurs on a cycle with m_axis_tvalid&m_axis_tready; then the register shifts left 8 and the count decrements.
REQ-021 m_axis_tdata SHALL be stable while m_axis_tvalid=1 and m_axis_tready=0.
REQ-022 After the 64th transfer, m_axis_tvalid SHALL be 0 the next cycle; the FSM enters RECV with count 20.
REQ-023 RECV: s_axis_tready=1; each s_axis_tvalid&s_axis_tready byte SHALL shift into the low end of a 160-bit capture register (shift left 8); m_axis_tvalid=0.
REQ-024 Accepting the 20th byte in cycle M SHALL update digest and pulse digest_valid in cycle M+1, with busy=0 and state IDLE in M+1.
REQ-025 digest SHALL hold its value until the next successful completion; aborted transactions SHALL NOT alter it.
REQ-026 start asserted in the cycle digest_valid is high SHALL be accepted (state is IDLE).
REQ-027 Counters SHALL be 7 bits (send) and 5 bits (receive); no wrap-around beyond 64/20 is permitted.

Reset
REQ-028 rst=1 SHALL force IDLE, busy=0, m_axis_tvalid=0, m_axis_tdata=0, digest=0, digest_valid=0, timeout_err=0, counters 0, next cycle after the edge.
REQ-029 Reset mid-SEND or mid-RECV SHALL abort with no digest_valid or timeout_err pulse.
REQ-030 s_axis_tready SHALL be 1 after reset (IDLE value).

Configuration
REQ-031 Macro SHA_HOST_TIMEOUT_EN defined: a 24-bit counter SHALL clear on entering RECV and on each accepted byte, increment each other RECV cycle; reaching TIMEOUT_CYCLES SHALL pulse timeout_err one cycle, keep digest unchanged, return to IDLE.
REQ-032 Macro undefined: no counter SHALL be built; timeout_err tied 0; RECV waits indefinitely.

Verification
REQ-033 Block = bytes 0x00..0x3F, m_axis_tready=1 always -> 64 bytes out in order 0x00..0x3F on 64 consecutive cycles; then 20 reply bytes 0xA0..0xB3 -> digest=0xA0A1..B3, one digest_valid pulse.
REQ-034 m_axis_tready toggled pseudo-randomly -> byte order unchanged, tdata stable while stalled, exactly 64 transfers.
REQ-035 start pulsed again during SEND with a different block -> ignored; output bytes match the first block.
REQ-036 rst asserted after byte 30 sent -> m_axis_tvalid=0 next cycle, busy=0, no digest_valid; new start then sends full 64 bytes.
REQ-037 With SHA_HOST_TIMEOUT_EN, TIMEOUT_CYCLES=100, only 5 reply bytes given -> timeout_err pulse 100 cycles after 5th byte, digest unchanged, busy=0.
REQ-038 Stray s_axis bytes in IDLE -> accepted and discarded; later transaction digest unaffected.

Source files
------------

// File: rtl/sha_uart_host_if.sv
// Byte-stream link between the SHA host and the UART transmitter/receiver.
// master: the host side (drives m_axis bytes, accepts s_axis bytes).
// slave:  the UART side.
interface sha_uart_host_if;
    logic [7:0] m_axis_tdata;
    logic       m_axis_tvalid;
    logic       m_axis_tready;
    logic [7:0] s_axis_tdata;
    logic       s_axis_tvalid;
    logic       s_axis_tready;

    modport master (
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready,
        input  s_axis_tdata,
        input  s_axis_tvalid,
        output s_axis_tready
    );

    modport slave (
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready,
        output s_axis_tdata,
        output s_axis_tvalid,
        input  s_axis_tready
    );
endinterface

// File: rtl/sha_uart_host.sv
// SHA UART host: streams a 512-bit block out as 64 bytes (MSB byte first),
// then collects a 20-byte digest reply (first byte lands in the top byte).
// Optional response timeout enabled by defining SHA_HOST_TIMEOUT_EN.
module sha_uart_host #(
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [511:0]          block,
    output logic                  busy,
    sha_uart_host_if.master       uart,
    output logic [159:0]          digest,
    output logic                  digest_valid,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {IDLE, SEND, RECV} state_t;

    state_t       state;
    state_t       state_next;
    logic [511:0] shreg;
    logic [6:0]   scnt;
    logic [4:0]   rcnt;
    logic [159:0] cap;
    logic         m_fire;
    logic         s_fire;
    logic         done;
    logic         tmo_hit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode and handshake outputs
    always_comb begin
        state_next         = state;
        busy               = (state != IDLE);
        uart.m_axis_tvalid = 1'b0;
        uart.m_axis_tdata  = shreg[511:504];
        uart.s_axis_tready = 1'b1;
        m_fire             = 1'b0;
        s_fire             = 1'b0;
        done               = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = SEND;
            end
            SEND: begin
                uart.m_axis_tvalid = 1'b1;
                uart.s_axis_tready = 1'b0;
                m_fire             = uart.m_axis_tready;
                if (m_fire && scnt == 7'd1) state_next = RECV;
            end
            RECV: begin
                s_fire = uart.s_axis_tvalid;
                if (s_fire && rcnt == 5'd1) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end else if (tmo_hit) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Shift registers, byte counters and result pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg        <= '0;
            scnt         <= '0;
            rcnt         <= '0;
            cap          <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            digest_valid <= done;
            timeout_err  <= tmo_hit;
            case (state)
                IDLE: begin
                    if (start) begin
                        shreg <= block;
                        scnt  <= 7'd64;
                    end
                end
                SEND: begin
                    if (m_fire) begin
                        shreg <= {shreg[503:0], 8'h00};
                        scnt  <= scnt - 7'd1;
                        if (scnt == 7'd1) rcnt <= 5'd20;
                    end
                end
                RECV: begin
                    if (s_fire) begin
                        cap  <= {cap[151:0], uart.s_axis_tdata};
                        rcnt <= rcnt - 5'd1;
                        if (rcnt == 5'd1) digest <= {cap[151:0], uart.s_axis_tdata};
                    end else if (tmo_hit) begin
                        rcnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef SHA_HOST_TIMEOUT_EN
    logic [23:0] tmo;

    // Idle-response counter: held at zero outside RECV, cleared by each byte
    always_ff @(posedge clk) begin
        if (rst || state != RECV) tmo <= '0;
        else if (uart.s_axis_tvalid) tmo <= '0;
        else                         tmo <= tmo + 24'd1;
    end

    // Abort when the idle count is about to reach the limit
    always_comb begin
        tmo_hit = (state == RECV) && !uart.s_axis_tvalid &&
                  (tmo + 24'd1 == TIMEOUT_CYCLES);
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
    assign tmo_hit        = 1'b0;
`endif

endmodule
